// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage with PC, redirect and misalignment trap.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        NextPCSrc,
   input  logic [31:0] ALURes,
   input  logic        Advance,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] PC,
   output logic [31:0] PCInc,
   output logic [31:0] Instr,
   output logic [6:0]  OpCode,
   output logic [2:0]  Funct3,
   output logic [6:0]  Funct7,
   output logic        InstrValid,
   output logic        MisalignErr
);
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, ERROR} state_t;
   state_t state, state_nxt;
   logic fetch_done, adv, misalign;
   logic [31:0] pc_nxt;
   assign IMemReq  = state == FETCH;
   assign IMemAddr = PC;
   assign PCInc    = PC + 32'd4;
   assign OpCode   = Instr[6:0];
   assign Funct3   = Instr[14:12];
   assign Funct7   = Instr[31:25];
   always_comb begin
      fetch_done = state == FETCH && IMemAck;
      adv        = state == HOLD && InstrValid && Advance;
      misalign   = adv && NextPCSrc && ALURes[1];
      pc_nxt     = NextPCSrc ? ALURes & 32'hFFFF_FFFE : PCInc;
      state_nxt  = state == BOOT ? FETCH :
                   fetch_done    ? HOLD  :
                   misalign      ? ERROR :
                   adv           ? FETCH : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         PC          <= RESET_PC;
         Instr       <= NOP_INSTR;
         InstrValid  <= 1'b0;
         MisalignErr <= 1'b0;
      end else begin
         state <= state_nxt;
         if (fetch_done) begin
            Instr      <= IMemData;
            InstrValid <= 1'b1;
         end
         if (adv) InstrValid <= 1'b0;
         if (adv && !misalign) PC <= pc_nxt;
         if (misalign) MisalignErr <= 1'b1;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized fetch/advance traffic with a queue scoreboard and a PC reference model.
module tb_instr_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        NextPCSrc = 1'b0;
   logic [31:0] ALURes = '0;
   logic        Advance = 1'b0;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck = 1'b0;
   logic [31:0] IMemData = '0;
   logic [31:0] PC, PCInc, Instr;
   logic [6:0]  OpCode, Funct7;
   logic [2:0]  Funct3;
   logic        InstrValid, MisalignErr;

   instr_fetch dut (
      .clk(clk), .rst(rst), .NextPCSrc(NextPCSrc), .ALURes(ALURes), .Advance(Advance),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
      .PC(PC), .PCInc(PCInc), .Instr(Instr), .OpCode(OpCode), .Funct3(Funct3),
      .Funct7(Funct7), .InstrValid(InstrValid), .MisalignErr(MisalignErr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] addr_q[$];
   logic [63:0] instr_q[$];
   logic [31:0] model_pc;
   logic        model_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected request address is pushed whenever the model decides where the next fetch goes.
   task automatic do_reset(input logic ack_in_reset, input logic boot_ack);
      rst      = 1'b1;
      IMemAck  = ack_in_reset;
      IMemData = 32'hDEAD_BEEF;
      Advance  = 1'($urandom);
      addr_q.delete();
      instr_q.delete();
      step();
      chk("rst_valid", 32'(InstrValid), 32'd0);
      chk("rst_instr", Instr, NOP);
      chk("rst_pc", PC, RESET_PC);
      chk("rst_misalign", 32'(MisalignErr), 32'd0);
      chk("rst_req", 32'(IMemReq), 32'd0);
      model_pc  = RESET_PC;
      model_err = 1'b0;
      addr_q.push_back(RESET_PC);
      rst     = 1'b0;
      Advance = 1'b0;
      IMemAck = boot_ack;
      step();
      IMemAck = 1'b0;
      chk("boot_req", 32'(IMemReq), 32'd1);
      chk("boot_addr", IMemAddr, RESET_PC);
      chk("boot_valid", 32'(InstrValid), 32'd0);
   endtask

   task automatic fetch(input int waits, input logic [31:0] data);
      for (int k = 0; k < 20 && !IMemReq; k++) step();
      if (!IMemReq) begin
         n_chk++;
         n_fail++;
         $display("FAIL fetch_timeout: IMemReq=%b, required 1", IMemReq);
         return;
      end
      for (int w = 0; w < waits; w++) begin
         IMemAck  = 1'b0;
         IMemData = $urandom;
         Advance  = 1'($urandom);
         step();
      end
      IMemAck  = 1'b1;
      IMemData = data;
      Advance  = 1'($urandom);
      instr_q.push_back({model_pc, data});
      step();
      IMemAck = 1'b0;
      Advance = 1'b0;
      chk("fetch_valid", 32'(InstrValid), 32'd1);
      chk("fetch_req_off", 32'(IMemReq), 32'd0);
   endtask

   task automatic advance(input logic src, input logic [31:0] alu);
      logic [31:0] nxt;
      int idle;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
         Advance   = 1'b0;
         IMemAck   = 1'($urandom);
         IMemData  = $urandom;
         NextPCSrc = 1'($urandom);
         ALURes    = $urandom;
         step();
      end
      IMemAck   = 1'($urandom);
      IMemData  = $urandom;
      Advance   = 1'b1;
      NextPCSrc = src;
      ALURes    = alu;
      step();
      Advance  = 1'b0;
      IMemAck  = 1'b0;
      if (src && alu[1]) begin
         model_err = 1'b1;
         chk("err_flag", 32'(MisalignErr), 32'd1);
         chk("err_valid", 32'(InstrValid), 32'd0);
         for (int i = 0; i < 4; i++) begin
            chk("err_req", 32'(IMemReq), 32'd0);
            chk("err_pc", PC, model_pc);
            chk("err_sticky", 32'(MisalignErr), 32'd1);
            Advance   = 1'($urandom);
            IMemAck   = 1'($urandom);
            NextPCSrc = 1'($urandom);
            ALURes    = $urandom;
            step();
         end
         Advance = 1'b0;
         IMemAck = 1'b0;
      end else begin
         nxt      = src ? {alu[31:1], 1'b0} : model_pc + 32'd4;
         model_pc = nxt;
         addr_q.push_back(nxt);
         chk("adv_pc", PC, nxt);
         chk("adv_pcinc", PCInc, nxt + 32'd4);
         chk("adv_valid", 32'(InstrValid), 32'd0);
         chk("adv_req", 32'(IMemReq), 32'd1);
      end
   endtask

   initial begin : monitor
      logic pv;
      logic [31:0] cpc, cins;
      logic [63:0] e;
      pv = 1'b0;
      cpc = '0;
      cins = '0;
      forever begin
         @(negedge clk);
         if (rst) pv = 1'b0;
         else begin
            if (IMemReq) begin
               if (addr_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL req_unexpected: request at %h, required none", IMemAddr);
               end else begin
                  chk("req_addr", IMemAddr, addr_q[0]);
                  if (IMemAck) void'(addr_q.pop_front());
               end
            end
            if (InstrValid && !pv) begin
               if (instr_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL valid_unexpected: InstrValid=1 with Instr %h, required 0", Instr);
               end else begin
                  e = instr_q.pop_front();
                  cpc = e[63:32];
                  cins = e[31:0];
                  chk("instr", Instr, cins);
                  chk("pc", PC, cpc);
                  chk("pcinc", PCInc, cpc + 32'd4);
                  chk("opcode", 32'(OpCode), 32'(cins[6:0]));
                  chk("funct3", 32'(Funct3), 32'(cins[14:12]));
                  chk("funct7", 32'(Funct7), 32'(cins[31:25]));
               end
            end else if (InstrValid) begin
               chk("hold_instr", Instr, cins);
               chk("hold_pc", PC, cpc);
            end
            pv = InstrValid;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1);
   end

   initial begin : driver
      logic src;
      logic [31:0] alu;
      do_reset(1'b0, 1'b1);
      fetch(2, 32'h0000_0033);
      chk("r22_opcode", 32'(OpCode), 32'h33);
      chk("r22_funct3", 32'(Funct3), 32'd0);
      chk("r22_funct7", 32'(Funct7), 32'd0);
      advance(1'b0, 32'h0);
      chk("r23_pc", PC, 32'h4);
      chk("r23_pcinc", PCInc, 32'h8);
      fetch(0, $urandom);
      advance(1'b1, 32'h0000_0101);
      chk("r24_pc", PC, 32'h100);
      fetch(1, $urandom);
      advance(1'b1, 32'hFFFF_FFFC);
      fetch(3, $urandom);
      advance(1'b0, $urandom);
      chk("r26_wrap", PC, 32'h0);
      for (int t = 0; t < 40; t++) begin
         fetch($urandom_range(0, 3), $urandom);
         src = 1'($urandom);
         alu = $urandom;
         if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
         advance(src, alu);
         if (model_err) do_reset(1'b0, 1'($urandom));
      end
      fetch(0, $urandom);
      advance(1'b0, 32'h0);
      step();
      do_reset(1'b1, 1'b1);
      fetch(1, 32'h0010_0093);
      advance(1'b1, 32'h0000_0102);
      chk("r25_pc", PC, RESET_PC);
      do_reset(1'b0, 1'b0);
      fetch(0, $urandom);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL set the instruction-register reset value (addi x0,x0,0).
REQ-003 Port list, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- NextPCSrc  input  1  1 = take the branch/jump target; sampled only on an accepted Advance.
- ALURes  input  32  branch/jump target address from the ALU.
- Advance  input  1  the downstream stage has consumed the current instruction.
- IMemReq  output  1  instruction-memory request.
- IMemAddr  output  32  request address; always equals PC.
- IMemAck  input  1  memory returns data this cycle.
- IMemData  input  32  instruction word; valid when IMemAck=1.
- PC  output  32  address of the held instruction.
- PCInc  output  32  PC+4, used as the JAL/JALR link value.
- Instr  output  32  registered instruction word.
- OpCode  output  7  Instr[6:0], to the control unit.
- Funct3  output  3  Instr[14:12], to the control unit.
- Funct7  output  7  Instr[31:25], to the control unit.
- InstrValid  output  1  Instr is valid and awaiting consumption.
- MisalignErr  output  1  sticky flag: a redirect target was misaligned.

Function
REQ-004 The block SHALL implement a 4-state FSM: BOOT, FETCH, HOLD, ERROR.
REQ-005 BOOT SHALL go to FETCH unconditionally on the next edge; IMemReq SHALL be 0 in BOOT.
REQ-006 IMemReq SHALL be 1 exactly while in FETCH.
REQ-007 In FETCH, IMemReq and IMemAddr SHALL stay stable until IMemAck=1.
REQ-008 In FETCH with IMemAck=1, the block SHALL, on that edge:
- load Instr from IMemData;
- set InstrValid=1;
- go to HOLD.
REQ-009 Ack in the same cycle as the request SHALL be legal, giving 1-cycle fetch latency; there is no limit on wait cycles.
REQ-010 IMemAck SHALL be ignored in BOOT, HOLD and ERROR.
REQ-011 In HOLD, Instr and PC SHALL stay constant until Advance=1; Advance SHALL be ignored when InstrValid=0.
REQ-012 On Advance in HOLD, the block SHALL compute the next PC as follows:
- NextPCSrc=0: next PC = PC+4, mod 2^32, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
- NextPCSrc=1: next PC = {ALURes[31:1],1'b0}.
REQ-013 On Advance with a valid next PC, the block SHALL on the next edge:
- update PC to the next PC;
- clear InstrValid;
- go to FETCH.
REQ-014 If NextPCSrc=1 and ALURes[1]=1 on Advance, the block SHALL on the next edge:
- go to ERROR;
- set MisalignErr=1;
- clear InstrValid;
- leave PC unchanged.
REQ-015 ERROR SHALL be terminal: no requests, MisalignErr held at 1, exit only via rst.
REQ-016 OpCode, Funct3 and Funct7 SHALL be combinational slices of Instr. PCInc SHALL be combinational PC+4.
REQ-017 Instr SHALL keep its last value when InstrValid=0; downstream gates on InstrValid.

Reset
REQ-018 With rst=1 at an edge, the block SHALL set: state=BOOT, PC=RESET_PC, Instr=NOP_INSTR, InstrValid=0, MisalignErr=0, IMemReq=0.
REQ-019 Reset SHALL take priority over all inputs, including a simultaneous IMemAck or Advance.
REQ-020 A reset mid-fetch SHALL abandon the outstanding request.
REQ-021 An ack arriving in BOOT after reset SHALL be ignored.

Verification
REQ-022 Reset release, ack after 2 wait cycles with IMemData=32'h0000_0033 -> required response:
- IMemReq=1 from cycle 1 after release;
- IMemAddr=0 throughout the request;
- InstrValid=1 on the edge after the ack;
- OpCode=7'b0110011, Funct3=0, Funct7=0.
REQ-023 Advance with NextPCSrc=0 at PC=0 -> PC=4, PCInc=8, IMemReq=1 the next cycle.
REQ-024 Advance with NextPCSrc=1, ALURes=32'h0000_0101 -> PC=32'h0000_0100 (bit 0 cleared), fetch issued at 32'h100.
REQ-025 Advance with NextPCSrc=1, ALURes=32'h0000_0102 -> MisalignErr=1, IMemReq stays 0, PC unchanged, until rst.
REQ-026 PC=32'hFFFF_FFFC, Advance with NextPCSrc=0 -> PC=0.
REQ-027 Reset edge mid-FETCH coinciding with IMemAck=1 -> required response:
- InstrValid=0;
- Instr=32'h0000_0013;
- first request after release at RESET_PC.
